// File: rtl/egress_serializer_pkg.sv
// Shared definitions for the egress serializer: FSM encoding and frame layout.
package egress_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam int unsigned FRAME_LEN         = 12;
    localparam logic        START_BIT         = 1'b1;
    localparam int          WORD_SIZE_DEFAULT = 10;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester at or above ptr, modulo 4.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       grant_valid
);

    logic [1:0] cand;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!grant_valid && req[cand]) begin
                grant       = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/egress_serializer.sv
// Drains four output FIFOs round-robin and sends each word as a 12-bit
// frame: start bit, d9..d0, even parity.
module egress_serializer
    import egress_serializer_pkg::*;
#(
    parameter int FIFO_WORD_SIZE = WORD_SIZE_DEFAULT,
    parameter int NUM_LANES      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [FIFO_WORD_SIZE-1:0] data_out0,
    input  logic [FIFO_WORD_SIZE-1:0] data_out1,
    input  logic [FIFO_WORD_SIZE-1:0] data_out2,
    input  logic [FIFO_WORD_SIZE-1:0] data_out3,
    input  logic [3:0]                fifo_empty,
    output logic                      pop_FIFO_out0,
    output logic                      pop_FIFO_out1,
    output logic                      pop_FIFO_out2,
    output logic                      pop_FIFO_out3,
    output logic                      serial_out,
    output logic                      serial_valid,
    output logic [1:0]                lane_id,
    output logic                      busy,
    output logic [7:0]                words_sent
);

    state_t                    state, state_nxt;
    logic [1:0]                rr_ptr;
    logic [FRAME_LEN-1:0]      shreg;
    logic [3:0]                bit_idx;
    logic [1:0]                grant;
    logic                      grant_valid;
    logic [3:0]                pops;
    logic                      last_bit;
    logic [FIFO_WORD_SIZE-1:0] heads [NUM_LANES];

    assign heads[0] = data_out0;
    assign heads[1] = data_out1;
    assign heads[2] = data_out2;
    assign heads[3] = data_out3;

    assign pop_FIFO_out0 = pops[0];
    assign pop_FIFO_out1 = pops[1];
    assign pop_FIFO_out2 = pops[2];
    assign pop_FIFO_out3 = pops[3];

    assign last_bit = (bit_idx == 4'(FRAME_LEN - 1));

    rr_arbiter4 u_arb (
        .req         (~fifo_empty),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_nxt    = state;
        pops         = '0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable && grant_valid) state_nxt = POP;
            end
            POP: begin
                pops[lane_id] = 1'b1;
                state_nxt     = LOAD;
            end
            LOAD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                serial_out   = shreg[FRAME_LEN-1];
                serial_valid = 1'b1;
                if (last_bit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The whole frame is assembled at LOAD and shifted out MSB first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lane_id    <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            words_sent <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (enable && grant_valid) lane_id <= grant;
                end
                LOAD: begin
                    shreg   <= {START_BIT, heads[lane_id], ^heads[lane_id]};
                    bit_idx <= '0;
                end
                SHIFT: begin
                    shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
                    if (last_bit) begin
                        bit_idx    <= '0;
                        words_sent <= words_sent + 8'd1;
                        rr_ptr     <= lane_id + 2'd1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_egress_serializer.sv
// Directed bench for egress_serializer with a behavioural registered-read FIFO per lane.
module tb_egress_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] dout [4];
    logic [3:0] fifo_empty;
    logic       p0, p1, p2, p3;
    logic       serial_out, serial_valid, busy;
    logic [1:0] lane_id;
    logic [7:0] words_sent;
    logic [3:0] pops;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [9:0]  mem [4][8];
    int unsigned loaded [4];
    int unsigned consumed [4];

    int unsigned cyc = 0;
    int unsigned pop_total = 0;
    int unsigned frames_seen = 0;
    logic        prev_valid = 1'b0;
    logic [1:0]  pop_lane [$];
    int unsigned pop_cyc [$];

    always #5 clk = ~clk;

    assign pops = {p3, p2, p1, p0};

    egress_serializer #(.FIFO_WORD_SIZE(10), .NUM_LANES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_out0     (dout[0]),
        .data_out1     (dout[1]),
        .data_out2     (dout[2]),
        .data_out3     (dout[3]),
        .fifo_empty    (fifo_empty),
        .pop_FIFO_out0 (p0),
        .pop_FIFO_out1 (p1),
        .pop_FIFO_out2 (p2),
        .pop_FIFO_out3 (p3),
        .serial_out    (serial_out),
        .serial_valid  (serial_valid),
        .lane_id       (lane_id),
        .busy          (busy),
        .words_sent    (words_sent)
    );

    always_comb begin
        fifo_empty = '0;
        for (int i = 0; i < 4; i++) fifo_empty[i] = (loaded[i] == consumed[i]);
    end

    // Registered-read FIFO: head word appears the cycle after the pop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (pops[i] && loaded[i] != consumed[i]) begin
                dout[i]     <= mem[i][consumed[i] % 8];
                consumed[i] <= consumed[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pops[i]) begin
                pop_lane.push_back(2'(i));
                pop_cyc.push_back(cyc);
                pop_total++;
            end
        end
        if (prev_valid && !serial_valid) frames_seen++;
        prev_valid = serial_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int lane, input logic [9:0] word, input int unsigned n);
        for (int unsigned k = 0; k < n; k++)
            mem[lane][(loaded[lane] + k) % 8] = word;
        loaded[lane] = loaded[lane] + n;
    endtask

    task automatic wait_valid(input string tag);
        int budget = 0;
        while (serial_valid !== 1'b1 && budget < 80) begin
            @(negedge clk);
            budget++;
        end
        if (serial_valid !== 1'b1) check(tag, {31'b0, serial_valid}, 32'd1);
    endtask

    task automatic capture(input string tag, input int drop_at,
                           output logic [11:0] frame, output logic [1:0] lane);
        int unsigned bad = 0;
        frame = '0;
        wait_valid(tag);
        lane = lane_id;
        for (int b = 0; b < 12; b++) begin
            if (serial_valid !== 1'b1) bad++;
            frame = {frame[10:0], serial_out};
            if (b == drop_at) enable = 1'b0;
            @(negedge clk);
        end
        check({tag, "_valid_held"}, bad, 0);
        check({tag, "_valid_end"}, {31'b0, serial_valid}, 32'd0);
    endtask

    task automatic wait_words(input string tag, input logic [7:0] target, input int budget);
        int n = 0;
        while (words_sent !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {24'b0, words_sent}, {24'b0, target});
    endtask

    logic [11:0] fr;
    logic [1:0]  ln;
    int unsigned start, pt, base;
    int          n;

    initial begin
        for (int i = 0; i < 4; i++) begin
            loaded[i]   = 0;
            consumed[i] = 0;
        end
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'b0, busy}, 0);
        check("rst_valid", {31'b0, serial_valid}, 0);
        check("rst_sout",  {31'b0, serial_out}, 0);
        check("rst_words", {24'b0, words_sent}, 0);
        check("rst_lane",  {30'b0, lane_id}, 0);
        check("rst_pops",  {28'b0, pops}, 0);
        reset = 1'b0;

        // Single word on lane 0
        load(0, 10'h0A6, 1);
        enable = 1'b1;
        capture("a", -1, fr, ln);
        check("a_frame", {20'b0, fr}, 32'h94C);
        check("a_lane",  {30'b0, ln}, 0);
        check("a_words", {24'b0, words_sent}, 1);
        check("a_pops",  pop_total, 1);
        if (pop_lane.size() > 0) check("a_pop_lane", {30'b0, pop_lane[0]}, 0);

        // Single word on lane 3, odd number of ones
        load(3, 10'h389, 1);
        capture("b", -1, fr, ln);
        check("b_frame", {20'b0, fr}, 32'hF13);
        check("b_lane",  {30'b0, ln}, 3);
        check("b_words", {24'b0, words_sent}, 2);

        // All lanes busy: round-robin order and 15-cycle pop spacing
        start = pop_lane.size();
        load(0, 10'h0A6, 2);
        load(1, 10'h389, 1);
        load(2, 10'h0A6, 1);
        load(3, 10'h389, 1);
        wait_words("c_words", 8'd7, 120);
        repeat (2) @(negedge clk);
        check("c_pop_count", pop_lane.size() - start, 5);
        if (pop_lane.size() >= start + 5) begin
            check("c_lane0", {30'b0, pop_lane[start+0]}, 0);
            check("c_lane1", {30'b0, pop_lane[start+1]}, 1);
            check("c_lane2", {30'b0, pop_lane[start+2]}, 2);
            check("c_lane3", {30'b0, pop_lane[start+3]}, 3);
            check("c_lane4", {30'b0, pop_lane[start+4]}, 0);
            for (int k = 1; k < 5; k++)
                check("c_spacing", pop_cyc[start+k] - pop_cyc[start+k-1], 15);
        end

        // enable dropped mid-frame: frame completes, no new grant
        load(1, 10'h0A6, 1);
        load(1, 10'h389, 1);
        capture("d", 4, fr, ln);
        check("d_frame", {20'b0, fr}, 32'h94C);
        check("d_lane",  {30'b0, ln}, 1);
        pt = pop_total;
        repeat (30) @(negedge clk);
        check("d_no_pop",  pop_total, pt);
        check("d_idle",    {31'b0, busy}, 0);
        check("d_pending", loaded[1] - consumed[1], 1);
        check("d_words",   {24'b0, words_sent}, 8);
        enable = 1'b1;
        capture("d2", -1, fr, ln);
        check("d2_frame", {20'b0, fr}, 32'hF13);
        check("d2_words", {24'b0, words_sent}, 9);

        // Reset at frame bit 5 on lane 2; restart from lane 0
        load(2, 10'h389, 1);
        load(3, 10'h389, 1);
        load(0, 10'h0A6, 1);
        wait_valid("e_start");
        check("e_lane_pre", {30'b0, lane_id}, 2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("e_sout",  {31'b0, serial_out}, 0);
        check("e_valid", {31'b0, serial_valid}, 0);
        check("e_busy",  {31'b0, busy}, 0);
        check("e_words", {24'b0, words_sent}, 0);
        check("e_lane",  {30'b0, lane_id}, 0);
        reset = 1'b0;
        capture("e2", -1, fr, ln);
        check("e2_lane",  {30'b0, ln}, 0);
        check("e2_frame", {20'b0, fr}, 32'h94C);
        check("e2_words", {24'b0, words_sent}, 1);
        capture("e3", -1, fr, ln);
        check("e3_lane",  {30'b0, ln}, 3);
        check("e3_words", {24'b0, words_sent}, 2);

        // 256 frames: counter wraps to zero
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = frames_seen;
        load(1, 10'h0A6, 256);
        n = 0;
        while (frames_seen - base < 255 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("f_255_frames", frames_seen - base, 255);
        check("f_words_255", {24'b0, words_sent}, 255);
        n = 0;
        while (frames_seen - base < 256 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("f_256_frames", frames_seen - base, 256);
        check("f_words_wrap", {24'b0, words_sent}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
